fetch_buffer: RTL

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer.sv | 102 ++++++++++
 1 files changed

// File: rtl/fetch_buffer.sv
// Instruction prefetch buffer: single-outstanding-request fetcher feeding a small FIFO toward ID.
// Optional FETCH_BUF_PERF_EN adds a saturating stall_cnt output (cycles ID was ready but starved).
module fetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump,
    input  logic [15:0] PC_jump,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr_IF,
    output logic [15:0] PC,
    output logic        out_valid,
    input  logic        out_ready
`ifdef FETCH_BUF_PERF_EN
   ,output logic [15:0] stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = CW + 1;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fetch_buffer: DEPTH must be a power of two in 2..16");
    end

    logic [15:0]   fetch_pc;
    logic          inflight;
    logic [15:0]   inflight_addr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [15:0]   fifo_instr [DEPTH];
    logic [15:0]   fifo_pc    [DEPTH];

    logic push;
    logic pop;

    // Reserve a slot for the response still in flight so the FIFO can never overflow.
    assign imem_req  = rst && !jump &&
                       (({1'b0, count} + {{CW{1'b0}}, inflight}) < OW'(DEPTH));
    assign imem_addr = fetch_pc;

    assign out_valid = (count != '0);
    assign push      = inflight && !jump;
    assign pop       = out_valid && out_ready && !jump;

    assign instr_IF  = out_valid ? fifo_instr[rd_ptr] : 16'h0000;
    assign PC        = out_valid ? fifo_pc[rd_ptr]    : 16'h0000;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc      <= RESET_PC;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
        end else if (jump) begin
            // Redirect flushes everything, including the response arriving this cycle.
            fetch_pc <= PC_jump;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                inflight_addr <= fetch_pc;
                fetch_pc      <= fetch_pc + 16'd1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= inflight_addr;
        end
    end

`ifdef FETCH_BUF_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= 16'h0000;
        else if (out_ready && !out_valid && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule
